// File: rtl/rx_err_drop_fifo_if.sv
// AXI-Stream beat bundle for the 512-bit CMAC receive path.
// The master drives the beat; the slave answers with tready.
interface rx_err_drop_fifo_if;
    logic         tvalid;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic         tlast;
    logic         tuser_err;
    logic         tready;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser_err,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser_err,
        output tready
    );
endinterface

// File: rtl/rx_err_drop_fifo.sv
// Store-and-forward RX filter: releases only whole, error-free frames
// and drops errored or overflowing frames without stalling the input.
module rx_err_drop_fifo #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     cmac_clk,
    input  logic                     rstn,
    rx_err_drop_fifo_if.slave        s_axis_cmac,
    rx_err_drop_fifo_if.master       m_axis_box,
    output logic [31:0]              drop_err_cnt,
    output logic [31:0]              drop_ovf_cnt,
    output logic [31:0]              frame_ok_cnt
);

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } wr_state_t;

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [576:0] mem [DEPTH];

    wr_state_t   state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] commit_q, commit_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] used;
    logic        full;
    logic        mem_we;
    logic        inc_ok, inc_err, inc_ovf;
    logic        out_ld;

    logic         out_valid;
    logic [511:0] out_data;
    logic [63:0]  out_keep;
    logic         out_last;

    // The CMAC side cannot be stalled.
    assign s_axis_cmac.tready = 1'b1;

    assign used = wr_ptr_q - rd_ptr_q;
    assign full = (used == FULL_LVL);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        commit_d = commit_q;
        mem_we   = 1'b0;
        inc_ok   = 1'b0;
        inc_err  = 1'b0;
        inc_ovf  = 1'b0;
        if (s_axis_cmac.tvalid) begin
            unique case (state_q)
                PASS: begin
                    unique case (1'b1)
                        full && !s_axis_cmac.tlast: begin
                            wr_ptr_d = commit_q;
                            state_d  = DROP;
                        end
                        full && s_axis_cmac.tlast: begin
                            wr_ptr_d = commit_q;
                            inc_ovf  = 1'b1;
                        end
                        !full && !s_axis_cmac.tlast: begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                        !full && s_axis_cmac.tlast
                              && !s_axis_cmac.tuser_err: begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            commit_d = wr_ptr_q + 1'b1;
                            inc_ok   = 1'b1;
                        end
                        !full && s_axis_cmac.tlast
                              && s_axis_cmac.tuser_err: begin
                            wr_ptr_d = commit_q;
                            inc_err  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                DROP: begin
                    if (s_axis_cmac.tlast) begin
                        inc_ovf = 1'b1;
                        state_d = PASS;
                    end
                end
                default: state_d = PASS;
            endcase
        end
    end

    always_ff @(posedge cmac_clk) begin
        if (!rstn) begin
            state_q      <= PASS;
            wr_ptr_q     <= '0;
            commit_q     <= '0;
            drop_err_cnt <= '0;
            drop_ovf_cnt <= '0;
            frame_ok_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            commit_q <= commit_d;
            if (inc_ok)  frame_ok_cnt <= frame_ok_cnt + 32'd1;
            if (inc_err) drop_err_cnt <= drop_err_cnt + 32'd1;
            if (inc_ovf) drop_ovf_cnt <= drop_ovf_cnt + 32'd1;
        end
    end

    always_ff @(posedge cmac_clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= {s_axis_cmac.tlast,
                                      s_axis_cmac.tkeep,
                                      s_axis_cmac.tdata};
        end
    end

    // Committed beats never share an address with the write pointer.
    assign out_ld = (rd_ptr_q != commit_q)
                 && (!out_valid || m_axis_box.tready);

    always_ff @(posedge cmac_clk) begin
        if (!rstn) begin
            rd_ptr_q  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (out_ld) begin
            {out_last, out_keep, out_data} <= mem[rd_ptr_q[AW-1:0]];
            out_valid <= 1'b1;
            rd_ptr_q  <= rd_ptr_q + 1'b1;
        end else if (m_axis_box.tready) begin
            out_valid <= 1'b0;
        end
    end

    assign m_axis_box.tvalid    = out_valid;
    assign m_axis_box.tdata     = out_data;
    assign m_axis_box.tkeep     = out_keep;
    assign m_axis_box.tlast     = out_last;
    assign m_axis_box.tuser_err = 1'b0;

endmodule

// File: doc/rx_err_drop_fifo.md
# rx_err_drop_fifo

Store-and-forward frame filter on the receive path, between the CMAC RX AXI-Stream output and the user box's `s_axis_cmac_*` input. It buffers each incoming 512-bit frame whole. Only complete, error-free frames are released downstream; frames flagged with `tuser_err` and frames that overflow the buffer are discarded. The CMAC RX side has no backpressure, so loss is handled by dropping whole frames and counting them, never by stalling the input.

## Interface
Parameters:
- `DEPTH`, 512: buffer depth in 512-bit beats. Must be a power of 2, ≥ 4.
- `AW`, $clog2(DEPTH): address width. Derived; do not override.

Ports:
- `cmac_clk`  in  1: single clock for all logic.
- `rstn`  in  1: reset. Synchronous, active-low. One clock; reset is synchronous and active-low.
- `s_axis_cmac_tvalid`  in  1: input beat valid. There is no `tready`; every valid beat must be consumed.
- `s_axis_cmac_tdata`  in  512: input data.
- `s_axis_cmac_tkeep`  in  64: input byte enables.
- `s_axis_cmac_tlast`  in  1: last beat of the frame.
- `s_axis_cmac_tuser_err`  in  1: frame error. Meaningful only on the `tlast` beat.
- `m_axis_box_tvalid`  out  1: output beat valid.
- `m_axis_box_tdata`  out  512: output data.
- `m_axis_box_tkeep`  out  64: output byte enables.
- `m_axis_box_tlast`  out  1: output last beat.
- `m_axis_box_tuser_err`  out  1: tied to 0. Errored frames are never emitted.
- `m_axis_box_tready`  in  1: downstream ready.
- `drop_err_cnt`  out  32: count of frames dropped for `tuser_err`. Wraps.
- `drop_ovf_cnt`  out  32: count of frames dropped for overflow. Wraps.
- `frame_ok_cnt`  out  32: count of frames committed. Wraps.

## Operation
- Storage: DEPTH × 577-bit array holding {tlast, tkeep, tdata}.
- Pointers: all (AW+1)-bit, modular arithmetic.
  - `wr_ptr`: working write pointer.
  - `wr_commit`: end of the last committed frame.
  - `rd_ptr`: read pointer.
- Full: `wr_ptr - rd_ptr == DEPTH`.
- Committed data available: `rd_ptr != wr_commit`.
- Write FSM states are PASS and DROP. Reset enters PASS.
- PASS, on a valid beat:
  - Not full and not tlast: write the beat, `wr_ptr++`.
  - Not full, tlast, `tuser_err`=0: write the beat. `wr_ptr++`, `wr_commit` ← `wr_ptr+1`, `frame_ok_cnt++`.
  - Not full, tlast, `tuser_err`=1: do not write. `wr_ptr` ← `wr_commit`, `drop_err_cnt++`.
  - Full and not tlast: `wr_ptr` ← `wr_commit`, go to DROP.
  - Full and tlast: `wr_ptr` ← `wr_commit`, `drop_ovf_cnt++`, stay in PASS.
- DROP, on a valid beat:
  - All beats are discarded.
  - On tlast: `drop_ovf_cnt++` and return to PASS. `tuser_err` is ignored, so each dropped frame is counted exactly once, as overflow.
- Fullness is tested against `rd_ptr` in the current cycle. Reads freeing space in the same cycle do not prevent an overflow decision.
- Frames longer than DEPTH beats are always dropped as overflow.
- Read side:
  - Synchronous RAM read, followed by an output register (FWFT behaviour at the port).
  - The output register loads the next committed beat when `!m_axis_box_tvalid || m_axis_box_tready`.
  - `rd_ptr` advances only for beats loaded into the output register.
  - Output AXIS rules: once `tvalid` is asserted, tdata, tkeep and tlast hold stable until `tready`. `tvalid` never drops without a handshake.
- The read side never sees uncommitted beats. A rollback never moves `wr_ptr` below `rd_ptr`.

## Timing
- Reset (`rstn`=0 at a `cmac_clk` edge):
  - All pointers go to 0, FSM to PASS.
  - All counters go to 0.
  - `m_axis_box_tvalid`, tdata, tkeep, tlast and tuser_err go to 0.
  - Reset mid-frame discards buffered and in-flight data with no count. The first beat after reset is treated as the start of a frame.
- Latency:
  - A good tlast is accepted in cycle N with the buffer otherwise empty.
  - `wr_commit` updates at the end of N. The RAM read is issued in N+1.
  - `m_axis_box_tvalid`=1 in cycle N+2.
- Throughput: 1 beat/cycle sustained, on both input and output, while `tready` is held at 1.
- Back-to-back frames: no idle cycles are required between frames on either side.
- Simultaneous write and read in one cycle is legal at any occupancy.
- Counter increments are registered, visible the cycle after the triggering tlast.

## Test plan
- Single 4-beat good frame, tdata = beat index, last tkeep = 64'h0000_0000_FFFF_FFFF, tready=1 → 4 beats out in order. tvalid first high 2 cycles after the input tlast, last tkeep matches, `frame_ok_cnt`=1.
- Good 3-beat frame, then a 3-beat frame with `tuser_err`=1 on tlast, then a good 2-beat frame → only 5 beats out (3+2), `drop_err_cnt`=1, `frame_ok_cnt`=2.
- DEPTH=16, tready=0, three back-to-back 8-beat good frames → the first two are committed, the third is dropped, `drop_ovf_cnt`=1. Releasing tready emits exactly 16 beats.
- DEPTH=16, a 20-beat frame into an empty buffer → nothing is emitted, `drop_ovf_cnt`=1. A following 1-beat good frame is emitted normally.
- Random tready (50%) against 1000 random-length good frames (1–12 beats) with no overflow → output matches input beat-for-beat. tdata stays stable while tvalid && !tready, and tuser_err is always 0.
- Assert `rstn`=0 for 1 cycle mid-frame while the output is stalled with tvalid=1 → the next cycle shows tvalid=0 and all counters 0. A subsequent good frame passes intact.
